alu_share_arbiter: RTL

//  Shares one combinational ALU instance among N_REQ requesters.
//  - Round-robin arbitration; per-requester valid/ready request channels.
//  - A single registered response channel with valid/ready, tagged with the requester id.
//  - Sits between issue sources (integer pipe, AGU, branch unit) and the ALU.
//  - Drives the ALU operand/op inputs and captures its result/zero outputs.

---
 rtl/alu_share_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among N_REQ requesters,
// returning results through a single registered valid/ready channel tagged by id.
module alu_share_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned ID_W = $clog2(N_REQ)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [N_REQ-1:0]       req_valid_i,
   output logic [N_REQ-1:0]       req_ready_o,
   input  logic [N_REQ*WIDTH-1:0] req_a_i,
   input  logic [N_REQ*WIDTH-1:0] req_b_i,
   input  logic [N_REQ*4-1:0]     req_op_i,
   output logic [WIDTH-1:0]       alu_a_o,
   output logic [WIDTH-1:0]       alu_b_o,
   output logic [3:0]             alu_op_o,
   input  logic [WIDTH-1:0]       alu_result_i,
   input  logic                   alu_zero_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic [WIDTH-1:0]       rsp_result_o,
   output logic                   rsp_zero_o,
   output logic                   rsp_illegal_o
);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e           state_q;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_found;
   logic             can_accept;
   logic             xfer;
   logic             illegal;
   int unsigned      idx;
   logic [ID_W-1:0]  rsp_id_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_zero_q;
   logic             rsp_illegal_q;

   // A full response register may be drained and refilled in the same cycle.
   assign can_accept = (state_q == StEmpty) | rsp_ready_i;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % N_REQ;
         if (!gnt_found && req_valid_i[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
   end

   // Reset masks the handshake so nothing is accepted while rst_ni is low.
   assign xfer        = rst_ni & can_accept & gnt_found;
   assign req_ready_o = xfer ? (N_REQ'(1) << gnt_idx) : '0;

   always_comb begin
      alu_a_o  = '0;
      alu_b_o  = '0;
      alu_op_o = 4'd0;
      if (xfer) begin
         alu_a_o  = req_a_i[gnt_idx*WIDTH +: WIDTH];
         alu_b_o  = req_b_i[gnt_idx*WIDTH +: WIDTH];
         alu_op_o = req_op_i[gnt_idx*4 +: 4];
      end
   end

   assign illegal  = alu_op_o > 4'd9;
   assign rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= StEmpty;
         rr_ptr_q      <= '0;
         rsp_id_q      <= '0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
      end else if (xfer) begin
         state_q       <= StFull;
         rr_ptr_q      <= rr_ptr_d;
         rsp_id_q      <= gnt_idx;
         rsp_result_q  <= illegal ? '0 : alu_result_i;
         rsp_zero_q    <= illegal | alu_zero_i;
         rsp_illegal_q <= illegal;
      end else if (rsp_ready_i) begin
         state_q <= StEmpty;
      end
   end

   assign rsp_valid_o   = (state_q == StFull);
   assign rsp_id_o      = rsp_id_q;
   assign rsp_result_o  = rsp_result_q;
   assign rsp_zero_o    = rsp_zero_q;
   assign rsp_illegal_o = rsp_illegal_q;

endmodule
